// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   nsa_state_t : controller state encoding (IDLE, ADD, DONE)
//   NIBBLE_W    : width of one adder slice
package nibble_adder_pkg;

    typedef enum logic [1:0] {IDLE, ADD, DONE} nsa_state_t;

    localparam int unsigned NIBBLE_W = 4;

endpackage

// File: rtl/adder_4bit.sv
// 4-bit ripple adder slice.
//   a, b     : nibble operands
//   carry_in : carry into bit 0
//   sum      : 4-bit result
//   overflow : carry out of bit 3
module adder_4bit
    import nibble_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                carry_in,
    output logic [NIBBLE_W-1:0] sum,
    output logic                overflow
);

    always_comb begin
        {overflow, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, carry_in};
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder: a + b + carry_in on 4*NUM_NIBBLES-bit operands,
// one nibble per clock, least significant nibble first.
//   clk      : rising-edge clock
//   n_rst    : asynchronous active-low reset
//   start    : request a new addition (operands sampled with it)
//   a, b     : operands
//   carry_in : carry into nibble 0
//   busy     : addition in progress
//   done     : one-cycle pulse, sum/overflow just updated
//   sum      : last completed sum, held until the next completion
//   overflow : carry out of the top nibble of the last completed addition
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int unsigned NUM_NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          start,
    input  logic [NIBBLE_W*NUM_NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NUM_NIBBLES-1:0] b,
    input  logic                          carry_in,
    output logic                          busy,
    output logic                          done,
    output logic [NIBBLE_W*NUM_NIBBLES-1:0] sum,
    output logic                          overflow
);

    localparam int unsigned W  = NIBBLE_W * NUM_NIBBLES;
    localparam int unsigned CW = $clog2(NUM_NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NUM_NIBBLES - 1);

    nsa_state_t         state;
    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic [W-1:0]       work;
    logic               carry_reg;
    logic [CW-1:0]      nib_cnt;

    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_carry;
    logic [W-1:0]        work_next;

    adder_4bit u_slice (
        .a        (a_sh[NIBBLE_W-1:0]),
        .b        (b_sh[NIBBLE_W-1:0]),
        .carry_in (carry_reg),
        .sum      (slice_sum),
        .overflow (slice_carry)
    );

    // Result nibbles enter at the top so that after NUM_NIBBLES shifts
    // nibble 0 sits at the bottom.
    always_comb begin
        work_next = {slice_sum, work[W-1:NIBBLE_W]};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            work      <= '0;
            carry_reg <= 1'b0;
            nib_cnt   <= '0;
            sum       <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh      <= a;
                        b_sh      <= b;
                        carry_reg <= carry_in;
                        nib_cnt   <= '0;
                        state     <= ADD;
                    end
                end
                ADD: begin
                    work      <= work_next;
                    a_sh      <= a_sh >> NIBBLE_W;
                    b_sh      <= b_sh >> NIBBLE_W;
                    carry_reg <= slice_carry;
                    nib_cnt   <= nib_cnt + CW'(1);
                    if (nib_cnt == LAST) begin
                        sum      <= work_next;
                        overflow <= slice_carry;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (start) begin
                        a_sh      <= a;
                        b_sh      <= b;
                        carry_reg <= carry_in;
                        nib_cnt   <= '0;
                        state     <= ADD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == ADD);
    assign done = (state == DONE);

endmodule
